ibuf: RTL and testbench
=======================

# ibuf

Instruction buffer between fetch and decode. A DEPTH-entry FIFO of 16-bit instruction words that accepts pushes from the fetch unit and presents them to decode through a valid/ready handshake. Each entry is tagged with its instruction address, which the buffer derives itself from a running write PC. A taken-branch flush empties the buffer and re-seeds that PC.

## Interface
- DEPTH, 8, number of entries; power of two, minimum 2
- WIDTH, 16, instruction word width
- clk  in  1  clock; all state changes on posedge
- rst_n  in  1  reset, synchronous, active-low
- ib_push  in  1  fetch presents a word this cycle
- ib_push_data  in  WIDTH  instruction word
- ib_full  out  1  buffer cannot accept a push this cycle
- flush  in  1  taken branch: discard contents
- flush_target  in  16  address of the next word fetch will push after a flush
- out_valid  out  1  head entry available to decode
- out_data  out  WIDTH  head instruction word; 0 when out_valid=0
- out_pc  out  16  head instruction address; 0 when out_valid=0
- out_ready  in  1  decode consumes head when out_valid && out_ready
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- State:
  - storage of DEPTH × (WIDTH+16)
  - rd_ptr and wr_ptr, each $clog2(DEPTH) bits, wrapping mod DEPTH
  - count register
  - wr_pc, 16 bits
- Reset (rst_n=0 at posedge): rd_ptr=wr_ptr=0, count=0, wr_pc=16'h0000. Storage is not cleared.
- ib_full = (count == DEPTH). It is combinational from registers and does not depend on a same-cycle pop.
- Push accepted iff ib_push && !ib_full && !flush.
  - Stores {ib_push_data, wr_pc} at wr_ptr.
  - wr_ptr += 1; wr_pc += 1 (16-bit wrap, FFFF→0000).
- A push while ib_full is dropped with no state change. wr_pc does not advance.
- Pop occurs iff out_valid && out_ready && !flush; rd_ptr += 1.
- count:
  - += 1 on push only
  - −= 1 on pop only
  - unchanged on simultaneous push and pop
- out_valid = (count != 0). out_data and out_pc are read from the head entry, gated to 0 when invalid.
- Flush has priority over everything:
  - next state: rd_ptr=wr_ptr=0, count=0, wr_pc=flush_target
  - any same-cycle push is discarded
  - the head shown in the flush cycle is not retired; decode must drop it
- rst_n=0 overrides flush.

## Timing
- Push at edge N is visible on out_valid/out_data/out_pc after edge N (same cycle as count update). Push-to-out latency is 1 cycle without bypass.
- Throughput is 1 push and 1 pop per cycle sustained, with no bubbles when neither empty nor full.
- When full, a same-cycle pop frees a slot only from the next cycle on. Fetch sees ib_full=1 that cycle.
- Flush at edge N: out_valid=0 and ib_full=0 in cycle N+1. A push in cycle N+1 is tagged flush_target.
- No combinational path from ib_push/flush to ib_full.

## Configuration
- IBUF_BYPASS_EN defined: when count==0, ib_push=1 and flush=0, the buffer forwards the incoming word in the same cycle:
  - out_valid=1, out_data=ib_push_data, out_pc=wr_pc
  - if out_ready=1, the word is consumed, nothing is written, count stays 0, and wr_pc still increments
  - if out_ready=0, it is written normally
- IBUF_BYPASS_EN undefined: out_valid is purely registered and the 1-cycle latency always applies.

## Test plan
- Reset, then push A001..A008 with out_ready=0 (DEPTH=8):
  - count=8 and ib_full=1
  - 9th push A009 is dropped
  - out_pc sequence on drain is 0000..0007 with data A001..A008 in order
- Continuous push and pop with out_ready=1 for 20 cycles:
  - count holds 1 (0 with bypass)
  - each word emerges with consecutive pc, no gaps or duplicates
- Fill with 3 entries, then assert flush with flush_target=0040 alongside ib_push:
  - next cycle out_valid=0, count=0
  - next push B000 appears with out_pc=0040
- Full buffer, pop and push in the same cycle:
  - push dropped, count=7
  - the following push is accepted
- Push 16 words with wr_pc seeded via flush_target=FFFE: pc sequence wraps FFFE, FFFF, 0000, 0001…; pointer wrap preserves order.
- With IBUF_BYPASS_EN, empty buffer, push C0DE with out_ready=1:
  - out_valid=1 and out_data=C0DE in the same cycle
  - count stays 0

Source files
------------

// File: rtl/ibuf.sv
// Instruction buffer between fetch and decode: DEPTH-entry FIFO of instruction words tagged with a self-generated PC.
// Optional same-cycle bypass of an empty buffer is enabled by defining IBUF_BYPASS_EN.
module ibuf #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ib_push,
    input  logic [WIDTH-1:0]           ib_push_data,
    output logic                       ib_full,
    input  logic                       flush,
    input  logic [15:0]                flush_target,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [15:0]                out_pc,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH+15:0] r_mem [DEPTH];
    logic [AW-1:0]     r_rd_ptr;
    logic [AW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_count;
    logic [15:0]       r_wr_pc;

    logic              w_empty;
    logic              w_full;
    logic              w_bypass;
    logic              w_bypass_take;
    logic              w_push;
    logic              w_pop;
    logic [WIDTH+15:0] w_head;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_head  = r_mem[r_rd_ptr];

`ifdef IBUF_BYPASS_EN
    assign w_bypass = w_empty && ib_push && !flush;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed word that decode takes this cycle never enters storage.
    assign w_bypass_take = w_bypass && out_ready;
    assign w_push        = ib_push && !w_full && !flush && !w_bypass_take;
    assign w_pop         = !w_empty && out_ready && !flush;

    assign ib_full = w_full;
    assign count   = r_count;

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_pc    = '0;
        if (!w_empty) begin
            out_valid = 1'b1;
            out_data  = w_head[WIDTH+15:16];
            out_pc    = w_head[15:0];
        end else if (w_bypass) begin
            out_valid = 1'b1;
            out_data  = ib_push_data;
            out_pc    = r_wr_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_wr_ptr] <= {ib_push_data, r_wr_pc};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_wr_pc  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_wr_pc  <= flush_target;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_push || w_bypass_take) begin
                r_wr_pc <= r_wr_pc + 16'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_ibuf.sv
// Scoreboard bench for ibuf: the driver queues expected {data, pc} per accepted push,
// a negedge monitor pops and compares on every handshake.
module tb_ibuf;

    logic        clk;
    logic        rst_n;
    logic        ib_push;
    logic [15:0] ib_push_data;
    logic        ib_full;
    logic        flush;
    logic [15:0] flush_target;
    logic        out_valid;
    logic [15:0] out_data;
    logic [15:0] out_pc;
    logic        out_ready;
    logic [3:0]  count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] exp_q [$];
    logic [15:0] m_pc;

    ibuf #(.DEPTH(8), .WIDTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ib_push      (ib_push),
        .ib_push_data (ib_push_data),
        .ib_full      (ib_full),
        .flush        (flush),
        .flush_target (flush_target),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_pc       (out_pc),
        .out_ready    (out_ready),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every handshake retires the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !flush) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_out: got data %h pc %h expected nothing", out_data, out_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if ({out_data, out_pc} !== e) begin
                    n_errors++;
                    $display("FAIL out_word: got data %h pc %h expected data %h pc %h",
                             out_data, out_pc, e[31:16], e[15:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle with a push; acc says whether the bench expects it to be taken.
    task automatic push(input logic [15:0] d, input bit acc);
        ib_push      = 1'b1;
        ib_push_data = d;
        if (acc) begin
            exp_q.push_back({d, m_pc});
            m_pc = m_pc + 16'd1;
        end
        tick();
        ib_push = 1'b0;
    endtask

    task automatic do_flush(input logic [15:0] tgt, input bit with_push, input logic [15:0] d);
        flush        = 1'b1;
        flush_target = tgt;
        ib_push      = with_push;
        ib_push_data = d;
        exp_q.delete();
        m_pc = tgt;
        tick();
        flush   = 1'b0;
        ib_push = 1'b0;
    endtask

    task automatic drain(input int unsigned n);
        out_ready = 1'b1;
        for (int unsigned i = 0; i < n; i++) tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ib_push = 1'b0; ib_push_data = '0;
        flush = 1'b0; flush_target = '0; out_ready = 1'b0;
        m_pc = 16'h0000;
        tick(); tick();
        rst_n = 1'b1;

        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(ib_full), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_pc", 32'(out_pc), 32'd0);

        // Fill to DEPTH, overflow push dropped, drain in order.
        for (int unsigned i = 1; i <= 8; i++) push(16'hA000 + 16'(i), 1'b1);
        check("fill_count", 32'(count), 32'd8);
        check("fill_full", 32'(ib_full), 32'd1);
        push(16'hA009, 1'b0);
        check("drop_count", 32'(count), 32'd8);
        check("head_data", 32'(out_data), 32'h0000A001);
        check("head_pc", 32'(out_pc), 32'd0);
        drain(8);
        check("drained_count", 32'(count), 32'd0);
        check("drained_valid", 32'(out_valid), 32'd0);
        check("drained_data", 32'(out_data), 32'd0);

        // Sustained push and pop.
        out_ready = 1'b1;
        for (int unsigned i = 0; i < 20; i++) begin
            push(16'hD000 + 16'(i), 1'b1);
`ifdef IBUF_BYPASS_EN
            check("stream_count", 32'(count), 32'd0);
`else
            check("stream_count", 32'(count), 32'd1);
`endif
        end
        tick();
        out_ready = 1'b0;
        check("stream_end_count", 32'(count), 32'd0);

        // Flush with a same-cycle push.
        for (int unsigned i = 1; i <= 3; i++) push(16'hE000 + 16'(i), 1'b1);
        check("pre_flush_count", 32'(count), 32'd3);
        do_flush(16'h0040, 1'b1, 16'hE004);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_count", 32'(count), 32'd0);
        check("flush_full", 32'(ib_full), 32'd0);
        push(16'hB000, 1'b1);
        check("post_flush_pc", 32'(out_pc), 32'h00000040);
        check("post_flush_data", 32'(out_data), 32'h0000B000);
        drain(1);

        // Full buffer: pop and push in the same cycle, push is dropped.
        for (int unsigned i = 1; i <= 8; i++) push(16'hF000 + 16'(i), 1'b1);
        check("full2_full", 32'(ib_full), 32'd1);
        out_ready = 1'b1;
        push(16'hF009, 1'b0);
        out_ready = 1'b0;
        check("full_pop_count", 32'(count), 32'd7);
        check("full_pop_full", 32'(ib_full), 32'd0);
        push(16'hF00A, 1'b1);
        check("refill_count", 32'(count), 32'd8);
        drain(8);
        check("full_drain_count", 32'(count), 32'd0);

        // PC wrap through FFFF and pointer wrap.
        do_flush(16'hFFFE, 1'b0, 16'h0000);
        for (int unsigned i = 0; i < 6; i++) push(16'h5000 + 16'(i), 1'b1);
        check("wrap_head_pc", 32'(out_pc), 32'h0000FFFE);
        out_ready = 1'b1;
        for (int unsigned i = 6; i < 16; i++) push(16'h5000 + 16'(i), 1'b1);
        out_ready = 1'b0;
        check("wrap_count", 32'(count), 32'd6);
        drain(6);
        check("wrap_drain_count", 32'(count), 32'd0);

`ifdef IBUF_BYPASS_EN
        // Same-cycle forward into an empty buffer.
        out_ready    = 1'b1;
        ib_push      = 1'b1;
        ib_push_data = 16'hC0DE;
        exp_q.push_back({16'hC0DE, m_pc});
        #1;
        check("bypass_valid", 32'(out_valid), 32'd1);
        check("bypass_data", 32'(out_data), 32'h0000C0DE);
        m_pc = m_pc + 16'd1;
        tick();
        ib_push   = 1'b0;
        out_ready = 1'b0;
        check("bypass_count", 32'(count), 32'd0);
`endif

        tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
